// File: rtl/vram_write_arbiter.sv
// Framebuffer VRAM write-port owner: round-robin arbitration between two
// pixel-write requesters plus a built-in clear-screen sweep.
module vram_write_arbiter #(
    parameter int COLS       = 100,
    parameter int ROWS       = 75,
    parameter int CELL_SHIFT = 3,
    parameter bit BLANK_ONLY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        disp_en,
    input  logic        clear_req,
    input  logic [11:0] clear_color,
    output logic        clear_busy,
    output logic        clear_done,
    input  logic        req0,
    input  logic        req1,
    input  logic [6:0]  x0,
    input  logic [6:0]  x1,
    input  logic [6:0]  y0,
    input  logic [6:0]  y1,
    input  logic [11:0] color0,
    input  logic [11:0] color1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        oob_err,
    output logic [11:0] h_coord_w,
    output logic [10:0] v_coord_w,
    output logic [3:0]  data_r,
    output logic [3:0]  data_g,
    output logic [3:0]  data_b,
    output logic        w_en
);

    localparam logic [6:0] LAST_X = 7'(COLS - 1);
    localparam logic [6:0] LAST_Y = 7'(ROWS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state;
    logic [6:0]  sweepX;
    logic [6:0]  sweepY;
    logic [11:0] clrColor;
    logic        favour1;

    logic        stall;
    logic        elig0;
    logic        elig1;
    logic        anyElig;
    logic        pick1;
    logic [6:0]  selX;
    logic [6:0]  selY;
    logic [11:0] selColor;
    logic        selOob;

    // Requester selection; a requester granted last edge is masked so it cannot write twice.
    always_comb begin
        stall   = BLANK_ONLY & disp_en;
        elig0   = req0 & ~gnt0;
        elig1   = req1 & ~gnt1;
        anyElig = elig0 | elig1;
        pick1   = elig1 & (~elig0 | favour1);
        if (pick1) begin
            selX     = x1;
            selY     = y1;
            selColor = color1;
        end else begin
            selX     = x0;
            selY     = y0;
            selColor = color0;
        end
        selOob = (selX > LAST_X) || (selY > LAST_Y);
    end

    // Control FSM with all write-port outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sweepX     <= 7'd0;
            sweepY     <= 7'd0;
            clrColor   <= 12'd0;
            favour1    <= 1'b0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            oob_err    <= 1'b0;
            h_coord_w  <= 12'd0;
            v_coord_w  <= 11'd0;
            data_r     <= 4'd0;
            data_g     <= 4'd0;
            data_b     <= 4'd0;
            w_en       <= 1'b0;
        end else begin
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            oob_err    <= 1'b0;
            w_en       <= 1'b0;
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        sweepX     <= 7'd0;
                        sweepY     <= 7'd0;
                        clrColor   <= clear_color;
                        clear_busy <= 1'b1;
                    end else if (!stall && anyElig) begin
                        gnt0 <= ~pick1;
                        gnt1 <= pick1;
                        if (elig0 && elig1) begin
                            favour1 <= ~pick1;
                        end
                        // Out-of-range requests are consumed but leave the port untouched.
                        if (selOob) begin
                            oob_err <= 1'b1;
                        end else begin
                            w_en      <= 1'b1;
                            h_coord_w <= {5'd0, selX} << CELL_SHIFT;
                            v_coord_w <= {4'd0, selY} << CELL_SHIFT;
                            data_r    <= selColor[11:8];
                            data_g    <= selColor[7:4];
                            data_b    <= selColor[3:0];
                        end
                    end
                end
                CLEAR: begin
                    if (!stall) begin
                        w_en      <= 1'b1;
                        h_coord_w <= {5'd0, sweepX} << CELL_SHIFT;
                        v_coord_w <= {4'd0, sweepY} << CELL_SHIFT;
                        data_r    <= clrColor[11:8];
                        data_g    <= clrColor[7:4];
                        data_b    <= clrColor[3:0];
                        if (sweepX == LAST_X) begin
                            sweepX <= 7'd0;
                            if (sweepY == LAST_Y) begin
                                state      <= IDLE;
                                clear_busy <= 1'b0;
                                clear_done <= 1'b1;
                            end else begin
                                sweepY <= sweepY + 7'd1;
                            end
                        end else begin
                            sweepX <= sweepX + 7'd1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: reset, single write, alternation,
// round-robin favour, clear sweep with waiting requester, blanking stall.
module tb_vram_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_en, clear_req, req0, req1;
    logic [11:0] clear_color, color0, color1;
    logic [6:0]  x0, x1, y0, y1;

    logic        clear_busy, clear_done, gnt0, gnt1, oob_err, w_en;
    logic [11:0] h_coord_w;
    logic [10:0] v_coord_w;
    logic [3:0]  data_r, data_g, data_b;

    logic        bBusy, bDone, bGnt0, bGnt1, bOob, bWEn;
    logic [11:0] bH;
    logic [10:0] bV;
    logic [3:0]  bR, bG, bB;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    vram_write_arbiter dut (
        .clk(clk), .reset(reset), .disp_en(disp_en), .clear_req(clear_req),
        .clear_color(clear_color), .clear_busy(clear_busy), .clear_done(clear_done),
        .req0(req0), .req1(req1), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .color0(color0), .color1(color1), .gnt0(gnt0), .gnt1(gnt1), .oob_err(oob_err),
        .h_coord_w(h_coord_w), .v_coord_w(v_coord_w),
        .data_r(data_r), .data_g(data_g), .data_b(data_b), .w_en(w_en)
    );

    vram_write_arbiter #(.BLANK_ONLY(1'b1)) dutB (
        .clk(clk), .reset(reset), .disp_en(disp_en), .clear_req(clear_req),
        .clear_color(clear_color), .clear_busy(bBusy), .clear_done(bDone),
        .req0(req0), .req1(req1), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .color0(color0), .color1(color1), .gnt0(bGnt0), .gnt1(bGnt1), .oob_err(bOob),
        .h_coord_w(bH), .v_coord_w(bV),
        .data_r(bR), .data_g(bG), .data_b(bB), .w_en(bWEn)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs;
        disp_en = 1'b0; clear_req = 1'b0; clear_color = 12'h000;
        req0 = 1'b0; req1 = 1'b0;
        x0 = 7'd0; y0 = 7'd0; x1 = 7'd0; y1 = 7'd0;
        color0 = 12'h000; color1 = 12'h000;
    endtask

    task automatic applyReset;
        idleInputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        idleInputs();
        reset = 1'b0;
        #1;
        checkCount++; if ({w_en, gnt0, gnt1, oob_err, clear_busy, clear_done} !== 6'b0) $display("FAIL reset_flags got=%b exp=000000", {w_en, gnt0, gnt1, oob_err, clear_busy, clear_done}); else passCount++;
        checkCount++; if ({h_coord_w, v_coord_w, data_r, data_g, data_b} !== 35'd0) $display("FAIL reset_data got=%h exp=0", {h_coord_w, v_coord_w, data_r, data_g, data_b}); else passCount++;
        step();
        reset = 1'b1;
        req0 = 1'b1; x0 = 7'd1; y0 = 7'd1; color0 = 12'h111;
        req1 = 1'b1; x1 = 7'd2; y1 = 7'd2; color1 = 12'h222;
        step();
        step();
        checkCount++; if (gnt1 !== 1'b1 || w_en !== 1'b1) $display("FAIL pre_reset_gnt1 got gnt1=%b w_en=%b exp 1 1", gnt1, w_en); else passCount++;
        #2 reset = 1'b0;
        #1;
        checkCount++; if ({w_en, gnt0, gnt1, h_coord_w} !== 15'd0) $display("FAIL midreset_outputs got=%h exp=0", {w_en, gnt0, gnt1, h_coord_w}); else passCount++;
        #1 reset = 1'b1;
        step();
        checkCount++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || h_coord_w !== 12'd8) $display("FAIL post_reset_favour got gnt0=%b gnt1=%b h=%0d exp 1 0 8", gnt0, gnt1, h_coord_w); else passCount++;
    endtask

    task automatic test_single_write;
        applyReset();
        req0 = 1'b1; x0 = 7'd5; y0 = 7'd2; color0 = 12'hF00;
        step();
        checkCount++; if ({w_en, gnt0, gnt1, oob_err} !== 4'b1100) $display("FAIL single_flags got=%b exp=1100", {w_en, gnt0, gnt1, oob_err}); else passCount++;
        checkCount++; if (h_coord_w !== 12'd40 || v_coord_w !== 11'd16) $display("FAIL single_coord got h=%0d v=%0d exp 40 16", h_coord_w, v_coord_w); else passCount++;
        checkCount++; if ({data_r, data_g, data_b} !== 12'hF00) $display("FAIL single_data got=%h exp=F00", {data_r, data_g, data_b}); else passCount++;
        req0 = 1'b0;
        step();
        checkCount++; if (w_en !== 1'b0 || gnt0 !== 1'b0 || h_coord_w !== 12'd40) $display("FAIL single_after got w_en=%b gnt0=%b h=%0d exp 0 0 40", w_en, gnt0, h_coord_w); else passCount++;
    endtask

    task automatic test_back_to_back;
        applyReset();
        req0 = 1'b1; x0 = 7'd1; y0 = 7'd1; color0 = 12'h123;
        req1 = 1'b1; x1 = 7'd2; y1 = 7'd3; color1 = 12'h456;
        for (int i = 0; i < 6; i++) begin
            logic eg0;
            eg0 = ((i % 2) == 0);
            step();
            checkCount++; if (gnt0 !== eg0 || gnt1 !== !eg0 || w_en !== 1'b1) $display("FAIL alternate_%0d got gnt0=%b gnt1=%b w_en=%b exp %b %b 1", i, gnt0, gnt1, w_en, eg0, !eg0); else passCount++;
            checkCount++; if (h_coord_w !== (eg0 ? 12'd8 : 12'd16) || v_coord_w !== (eg0 ? 11'd8 : 11'd24)) $display("FAIL alternate_coord_%0d got h=%0d v=%0d", i, h_coord_w, v_coord_w); else passCount++;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_rr_favour;
        applyReset();
        req0 = 1'b1; req1 = 1'b1; x1 = 7'd9;
        step();
        checkCount++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) $display("FAIL rr_first got gnt0=%b gnt1=%b exp 1 0", gnt0, gnt1); else passCount++;
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        req0 = 1'b1; req1 = 1'b1;
        step();
        checkCount++; if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || h_coord_w !== 12'd72) $display("FAIL rr_second got gnt0=%b gnt1=%b h=%0d exp 0 1 72", gnt0, gnt1, h_coord_w); else passCount++;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_clear;
        int writes, sweepErr, doneSeen, earlyGnt, cycles;
        logic [11:0] lastH;
        logic [10:0] lastV;
        applyReset();
        clear_req = 1'b1; clear_color = 12'h00F;
        step();
        checkCount++; if (clear_busy !== 1'b1 || w_en !== 1'b0 || gnt0 !== 1'b0) $display("FAIL clear_start got busy=%b w_en=%b gnt0=%b exp 1 0 0", clear_busy, w_en, gnt0); else passCount++;
        clear_req = 1'b0; clear_color = 12'hFFF;
        req1 = 1'b1; x1 = 7'd100; y1 = 7'd0; color1 = 12'hABC;
        writes = 0; sweepErr = 0; doneSeen = 0; earlyGnt = 0; cycles = 0;
        lastH = 12'd0; lastV = 11'd0;
        while (doneSeen == 0 && cycles < 8000) begin
            step();
            cycles++;
            if (w_en === 1'b1) begin
                if (h_coord_w !== 12'((writes % 100) * 8) || v_coord_w !== 11'((writes / 100) * 8) || {data_r, data_g, data_b} !== 12'h00F) sweepErr++;
                writes++;
                lastH = h_coord_w; lastV = v_coord_w;
            end else begin
                sweepErr++;
            end
            if (gnt0 === 1'b1 || gnt1 === 1'b1) earlyGnt++;
            if (clear_done === 1'b1) doneSeen = 1;
        end
        checkCount++; if (doneSeen !== 1) $display("FAIL clear_timeout got done=%0d exp 1 within 8000 cycles", doneSeen); else passCount++;
        checkCount++; if (writes !== 7500 || sweepErr !== 0) $display("FAIL clear_count got writes=%0d errs=%0d exp 7500 0", writes, sweepErr); else passCount++;
        checkCount++; if (lastH !== 12'd792 || lastV !== 11'd592 || clear_busy !== 1'b0) $display("FAIL clear_last got h=%0d v=%0d busy=%b exp 792 592 0", lastH, lastV, clear_busy); else passCount++;
        checkCount++; if (earlyGnt !== 0) $display("FAIL clear_no_grant got=%0d exp=0", earlyGnt); else passCount++;
        step();
        checkCount++; if ({gnt1, oob_err, w_en, clear_done} !== 4'b1100) $display("FAIL oob_after_clear got=%b exp=1100", {gnt1, oob_err, w_en, clear_done}); else passCount++;
        checkCount++; if (h_coord_w !== 12'd792 || {data_r, data_g, data_b} !== 12'h00F) $display("FAIL oob_hold got h=%0d data=%h exp 792 00F", h_coord_w, {data_r, data_g, data_b}); else passCount++;
        req1 = 1'b0;
    endtask

    task automatic test_blank_stall;
        applyReset();
        disp_en = 1'b1;
        req0 = 1'b1; x0 = 7'd3; y0 = 7'd4; color0 = 12'h0F0;
        step();
        step();
        checkCount++; if (bWEn !== 1'b0 || bGnt0 !== 1'b0) $display("FAIL blank_stall got w_en=%b gnt0=%b exp 0 0", bWEn, bGnt0); else passCount++;
        disp_en = 1'b0;
        step();
        checkCount++; if (bWEn !== 1'b1 || bGnt0 !== 1'b1 || bH !== 12'd24 || bV !== 11'd32 || {bR, bG, bB} !== 12'h0F0) $display("FAIL blank_release got w_en=%b gnt0=%b h=%0d v=%0d data=%h exp 1 1 24 32 0F0", bWEn, bGnt0, bH, bV, {bR, bG, bB}); else passCount++;
        req0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_rr_favour();
        test_clear();
        test_blank_stall();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
